// File: rtl/reg_pkg.sv
// Shared register-file constants and helpers for the writeback block.
// Register 0 is hardwired zero and never written or tracked.
package reg_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic is_x0(reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Writeback bundle: ALU/LSU result offers, issue claim/query,
// and the registered register-file write port.
interface reg_wb_if
  import reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic                  alu_valid;
  reg_addr_t             alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  reg_addr_t             lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic                  iss_claim;
  reg_addr_t             iss_rd;
  reg_addr_t             rs1;
  reg_addr_t             rs2;
  logic                  busy1;
  logic                  busy2;

  logic                  wrEn;
  reg_addr_t             rd;
  logic [DATA_WIDTH-1:0] dIn;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output iss_claim, iss_rd, rs1, rs2,
    input  busy1, busy2,
    input  wrEn, rd, dIn
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  iss_claim, iss_rd, rs1, rs2,
    output busy1, busy2,
    output wrEn, rd, dIn
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result queue: wrapping pointers, 0..DEPTH occupancy count.
// Push is ignored when full, pop ignored when empty.
module wb_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback arbiter: ALU results and queued load results share one
// registered register-file write port; a scoreboard tracks pending loads.
module reg_wb_ctrl
  import reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int QDEPTH     = 4
) (
  input logic    clk,
  input logic    rst,
  reg_wb_if.slave bus
);

  localparam int EW = DATA_WIDTH + REG_ADDR_W;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_alu_acc;
  logic                  w_lsu_acc;
  logic                  w_enq;
  logic                  w_deq;
  logic [EW-1:0]         w_head;
  reg_addr_t             w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_d;
  logic [NUM_REGS-1:0]   w_sb_set;
  logic [NUM_REGS-1:0]   w_sb_clr;
  logic [NUM_REGS-1:0]   w_sb_nxt;

  logic [NUM_REGS-1:0]   r_sb;
  logic                  r_wr_en;
  reg_addr_t             r_rd;
  logic [DATA_WIDTH-1:0] r_din;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_enq),
    .i_data  ({bus.lsu_rd, bus.lsu_data}),
    .i_pop   (w_deq),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_rd = w_head[EW-1 -: REG_ADDR_W];
  assign w_head_d  = w_head[DATA_WIDTH-1:0];

  assign bus.alu_ready = !rst && !w_full;
  assign bus.lsu_ready = !rst && !w_full;

  assign w_alu_acc = bus.alu_valid && bus.alu_ready;
  assign w_lsu_acc = bus.lsu_valid && bus.lsu_ready;
  assign w_enq     = w_lsu_acc && !is_x0(bus.lsu_rd);
  // A full queue takes the port so the ALU cannot starve the loads.
  assign w_deq     = !rst && !w_empty
                   && (w_full || !bus.alu_valid);

  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (bus.iss_claim && !is_x0(bus.iss_rd))
      w_sb_set[bus.iss_rd] = 1'b1;
    if (w_deq)
      w_sb_clr[w_head_rd] = 1'b1;
    w_sb_nxt = (r_sb & ~w_sb_clr) | w_sb_set;
    w_sb_nxt[0] = 1'b0;
  end

  assign bus.busy1 = r_sb[bus.rs1];
  assign bus.busy2 = r_sb[bus.rs2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb    <= '0;
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_din   <= '0;
    end else begin
      r_sb <= w_sb_nxt;
      unique case (1'b1)
        w_alu_acc: begin
          r_wr_en <= !is_x0(bus.alu_rd);
          if (!is_x0(bus.alu_rd)) begin
            r_rd  <= bus.alu_rd;
            r_din <= bus.alu_data;
          end
        end
        w_deq: begin
          r_wr_en <= 1'b1;
          r_rd    <= w_head_rd;
          r_din   <= w_head_d;
        end
        default: r_wr_en <= 1'b0;
      endcase
    end
  end

  assign bus.wrEn = r_wr_en;
  assign bus.rd   = r_rd;
  assign bus.dIn  = r_din;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_reg_wb_ctrl;

  localparam int DW = 8;
  localparam int QD = 4;

  typedef struct packed {
    logic [2:0]    rd;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_wb_if #(.DATA_WIDTH(DW)) bus ();

  reg_wb_ctrl #(
    .DATA_WIDTH (DW),
    .QDEPTH     (QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t          mq[$];
  bit            msb[8];
  logic          exp_ar, exp_lr, exp_b1, exp_b2, exp_wr;
  logic [2:0]    exp_rd;
  logic [DW-1:0] exp_d;
  logic [15:0]   exp_v, obs_v;
  logic          obs_ar, obs_lr, obs_b1, obs_b2;

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_claim = 1'b0; bus.iss_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  // One clock: sample combinational outputs before the edge, apply the
  // reference rules at the edge, sample registered outputs after it.
  task automatic step();
    bit   full;
    bit   alu_acc;
    bit   lsu_acc;
    ent_t e;
    @(negedge clk);
    full   = (mq.size() == QD);
    exp_ar = !rst && !full;
    exp_lr = !rst && !full;
    exp_b1 = msb[bus.rs1];
    exp_b2 = msb[bus.rs2];
    obs_ar = bus.alu_ready;
    obs_lr = bus.lsu_ready;
    obs_b1 = bus.busy1;
    obs_b2 = bus.busy2;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      foreach (msb[i]) msb[i] = 1'b0;
      exp_wr = 1'b0;
      exp_rd = '0;
      exp_d  = '0;
    end else begin
      alu_acc = bus.alu_valid && !full;
      lsu_acc = bus.lsu_valid && !full;
      exp_wr  = 1'b0;
      if (alu_acc) begin
        if (bus.alu_rd != 0) begin
          exp_wr = 1'b1;
          exp_rd = bus.alu_rd;
          exp_d  = bus.alu_data;
        end
      end else if (mq.size() > 0) begin
        e      = mq.pop_front();
        exp_wr = 1'b1;
        exp_rd = e.rd;
        exp_d  = e.d;
        msb[e.rd] = 1'b0;
      end
      if (lsu_acc && bus.lsu_rd != 0)
        mq.push_back('{rd: bus.lsu_rd, d: bus.lsu_data});
      if (bus.iss_claim && bus.iss_rd != 0)
        msb[bus.iss_rd] = 1'b1;
    end
    #1;
    exp_v = {exp_ar, exp_lr, exp_b1, exp_b2, exp_wr, exp_rd, exp_d};
    obs_v = {obs_ar, obs_lr, obs_b1, obs_b2,
             bus.wrEn, bus.rd, bus.dIn};
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_model got %h exp %h", obs_v, exp_v);
      end
    end
    checks++;
    if (obs_v !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values got %h exp 0000", obs_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 8'h5A;
    step();
    checks++;
    if ({bus.wrEn, bus.rd, bus.dIn} !== {1'b1, 3'd3, 8'h5A}) begin
      errors++;
      $display("FAIL alu_only got %b/%0d/%h exp 1/3/5a",
               bus.wrEn, bus.rd, bus.dIn);
    end
    drive_idle();
    step();
    checks++;
    if ({bus.wrEn, bus.rd, bus.dIn} !== {1'b0, 3'd3, 8'h5A}) begin
      errors++;
      $display("FAIL idle_hold got %b/%0d/%h exp 0/3/5a",
               bus.wrEn, bus.rd, bus.dIn);
    end
  endtask

  task automatic test_contention();
    int n2;
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 8'h11;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 3'd2; bus.lsu_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.lsu_valid = 1'b0;
      checks++;
      if ({bus.wrEn, bus.rd, bus.dIn} !== {1'b1, 3'd1, 8'h11}) begin
        errors++;
        $display("FAIL contention_alu got %b/%0d/%h exp 1/1/11",
                 bus.wrEn, bus.rd, bus.dIn);
      end
    end
    bus.alu_valid = 1'b0;
    n2 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL contention_model got %h exp %h", obs_v, exp_v);
      end
      if (bus.wrEn && bus.rd == 3'd2 && bus.dIn == 8'h22) n2++;
    end
    checks++;
    if (n2 != 1) begin
      errors++;
      $display("FAIL contention_once got %0d writes exp 1", n2);
    end
  endtask

  task automatic test_full();
    logic [2:0] seq [$];
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_data  = 8'($urandom);
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 3'(i + 2);
      bus.lsu_data  = 8'(8'hA2 + i);
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL fill_model got %h exp %h", obs_v, exp_v);
      end
    end
    bus.lsu_valid = 1'b0;
    step();
    checks++;
    if ({obs_ar, obs_lr} !== 2'b00) begin
      errors++;
      $display("FAIL full_ready got %b%b exp 00", obs_ar, obs_lr);
    end
    checks++;
    if ({bus.wrEn, bus.rd, bus.dIn} !== {1'b1, 3'd2, 8'hA2}) begin
      errors++;
      $display("FAIL full_head got %b/%0d/%h exp 1/2/a2",
               bus.wrEn, bus.rd, bus.dIn);
    end
    step();
    checks++;
    if ({bus.wrEn, bus.rd} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL full_alu_back got %b/%0d exp 1/1", bus.wrEn, bus.rd);
    end
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seq.push_back(bus.rd);
      checks++;
      if ({bus.wrEn, bus.rd, bus.dIn} !==
          {1'b1, 3'(i + 3), 8'(8'hA3 + i)}) begin
        errors++;
        $display("FAIL drain_order got %b/%0d/%h exp 1/%0d/%h",
                 bus.wrEn, bus.rd, bus.dIn, i + 3, 8'hA3 + i);
      end
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd6; bus.alu_data = 8'h66;
    step();
    checks++;
    if ({obs_ar, bus.wrEn, bus.rd, bus.dIn} !==
        {1'b1, 1'b1, 3'd6, 8'h66}) begin
      errors++;
      $display("FAIL alu_resume got %b/%b/%0d/%h exp 1/1/6/66",
               obs_ar, bus.wrEn, bus.rd, bus.dIn);
    end
    drive_idle();
    step();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    bus.rs1 = 3'd5; bus.rs2 = 3'd5;
    bus.iss_claim = 1'b1; bus.iss_rd = 3'd5;
    step();
    bus.iss_claim = 1'b0;
    checks++;
    if ({bus.busy1, bus.busy2} !== 2'b11) begin
      errors++;
      $display("FAIL sb_claim got %b%b exp 11", bus.busy1, bus.busy2);
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 3'd5; bus.lsu_data = 8'h55;
    step();
    bus.lsu_valid = 1'b0;
    bus.iss_claim = 1'b1; bus.iss_rd = 3'd5;
    step();
    bus.iss_claim = 1'b0;
    checks++;
    if ({bus.busy1, bus.wrEn, bus.rd, bus.dIn} !==
        {1'b1, 1'b1, 3'd5, 8'h55}) begin
      errors++;
      $display("FAIL sb_reclaim got %b/%b/%0d/%h exp 1/1/5/55",
               bus.busy1, bus.wrEn, bus.rd, bus.dIn);
    end
    bus.lsu_valid = 1'b1; bus.lsu_data = 8'h56;
    step();
    bus.lsu_valid = 1'b0;
    checks++;
    if (bus.busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_queued got %b exp 1", bus.busy1);
    end
    step();
    checks++;
    if ({bus.busy1, bus.busy2, bus.wrEn, bus.rd} !==
        {1'b0, 1'b0, 1'b1, 3'd5}) begin
      errors++;
      $display("FAIL sb_clear got %b%b/%b/%0d exp 00/1/5",
               bus.busy1, bus.busy2, bus.wrEn, bus.rd);
    end
    bus.rs1 = 3'd0;
    bus.iss_claim = 1'b1; bus.iss_rd = 3'd0;
    step();
    bus.iss_claim = 1'b0;
    checks++;
    if (bus.busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_x0 got %b exp 0", bus.busy1);
    end
  endtask

  task automatic test_rd0();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 8'hFF;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 3'd0; bus.lsu_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.wrEn !== 1'b0 || obs_v !== exp_v) begin
        errors++;
        $display("FAIL rd0_accept got %h exp %h", obs_v, exp_v);
      end
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.wrEn !== 1'b0 || obs_lr !== 1'b1) begin
        errors++;
        $display("FAIL rd0_noq got wr=%b lr=%b exp wr=0 lr=1",
                 bus.wrEn, obs_lr);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      bus.lsu_valid = 1'b1; bus.lsu_rd = 3'(i + 2);
      bus.lsu_data  = 8'(8'hC0 + i);
      bus.iss_claim = 1'b1; bus.iss_rd = 3'(i + 2);
      step();
    end
    drive_idle();
    bus.rs1 = 3'd2; bus.rs2 = 3'd4;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.wrEn, bus.busy1, bus.busy2, obs_ar, obs_lr} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid got wr=%b b=%b%b rdy=%b%b exp all 0",
               bus.wrEn, bus.busy1, bus.busy2, obs_ar, obs_lr);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.wrEn !== 1'b0 || obs_v !== exp_v) begin
        errors++;
        $display("FAIL rst_stale got %h exp %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid = ($urandom_range(0, 99) < 50);
      bus.alu_rd    = 3'($urandom);
      bus.alu_data  = 8'($urandom);
      bus.lsu_valid = ($urandom_range(0, 99) < 45);
      bus.lsu_rd    = 3'($urandom);
      bus.lsu_data  = 8'($urandom);
      bus.iss_claim = ($urandom_range(0, 99) < 30);
      bus.iss_rd    = 3'($urandom);
      bus.rs1       = 3'($urandom);
      bus.rs2       = 3'($urandom);
      rst           = ($urandom_range(0, 99) < 2);
      step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] got %h exp %h", i, obs_v, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_alu_only();
    test_contention();
    test_full();
    test_scoreboard();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning register data width; it matches the register file's write data width.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning load-result queue depth; power of two, at least 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 alu_valid / alu_rd / alu_data  in  1 / 3 / DATA_WIDTH  single-cycle ALU result offer.
REQ-007 alu_ready  out  1  ALU result accepted this cycle.
REQ-008 lsu_valid / lsu_rd / lsu_data  in  1 / 3 / DATA_WIDTH  load result offer.
REQ-009 lsu_ready  out  1  load result accepted this cycle.
REQ-010 iss_claim / iss_rd  in  1 / 3  a load targeting iss_rd is issuing; mark iss_rd pending.
REQ-011 rs1 / rs2  in  3 / 3  issue-stage source register query.
REQ-012 busy1 / busy2  out  1 / 1  the queried register has a pending load write.
REQ-013 wrEn / rd / dIn  out  1 / 3 / DATA_WIDTH  registered register-file write port.

Function
REQ-014 SHALL drive at most one register-file write per cycle; wrEn, rd and dIn are registered, with 1-cycle latency from acceptance (ALU) or from dequeue (LSU).
REQ-015 SHALL hold accepted load results in a FIFO of QDEPTH entries with a 0..QDEPTH occupancy counter and wrapping read/write pointers.
REQ-016 SHALL assert lsu_ready = !fifo_full; a load is accepted when lsu_valid && lsu_ready.
REQ-017 Arbitration, normal case (FIFO not full): alu_ready=1; a valid ALU result wins the write port; the FIFO head dequeues only when alu_valid=0.
REQ-018 Arbitration when the FIFO is full: alu_ready=0; the FIFO head dequeues; the ALU holds its offer.
REQ-019 SHALL not bypass the queue; a load accepted at edge N drives wrEn no earlier than the cycle after edge N+1.
REQ-020 Enqueue and dequeue in the same cycle SHALL leave the occupancy unchanged.
REQ-021 rd=0 handling, ALU: an accepted ALU result with alu_rd=0 is consumed with wrEn=0.
REQ-022 rd=0 handling, LSU: an accepted LSU result with lsu_rd=0 is consumed and not enqueued.
REQ-023 SHALL keep an 8-bit scoreboard; bit 0 is constant 0.
REQ-024 Scoreboard set: iss_claim with iss_rd!=0 sets sb[iss_rd].
REQ-025 Scoreboard clear: a dequeued LSU entry clears sb[rd].
REQ-026 Set and clear of the same index in the same cycle SHALL leave the bit set.
REQ-027 busy1 = sb[rs1] and busy2 = sb[rs2], combinational; register 0 is never busy.
REQ-028 When no write occurs, SHALL drive wrEn=0 and hold rd and dIn at their previous values.

Reset
REQ-029 On rst, outputs SHALL reset to: wrEn=0, rd=0, dIn=0.
REQ-030 On rst, state SHALL reset to: FIFO empty, pointers=0, scoreboard=0.
REQ-031 Reset asserted mid-operation SHALL discard queued load results and pending marks with no write issued.
REQ-032 During reset, lsu_ready and alu_ready SHALL be 0.

Structure
REQ-033 Package reg_pkg SHALL hold REG_ADDR_W=3 and NUM_REGS=8.
REQ-034 The load queue SHALL be sub-module wb_fifo (parameters DATA_WIDTH+3 bits wide, QDEPTH deep, with full/empty flags).
REQ-035 Arbitration, scoreboard and output register SHALL reside in reg_wb_ctrl.

Verification
REQ-036 ALU only: alu_valid, alu_rd=3, alu_data=0x5A -> next cycle wrEn=1, rd=3, dIn=0x5A.
REQ-037 Contention: ALU(rd=1, 0x11) offered continuously plus one LSU(rd=2, 0x22) -> LSU waits; when ALU drops, rd=2/0x22 written exactly once.
REQ-038 Full queue: stall the drain with ALU traffic, then 4 LSU writes -> lsu_ready=0 and alu_ready=0; heads drain in FIFO order; ALU resumes afterwards.
REQ-039 Scoreboard: iss_claim rd=5, then rs1=5 -> busy1=1 until the LSU rd=5 write leaves; same-cycle re-claim of 5 keeps busy1=1.
REQ-040 rd=0: ALU and LSU results to rd=0 -> wrEn stays 0 and the FIFO count stays 0.
REQ-041 Reset with 3 queued entries -> wrEn=0, busy flags 0, no stale writes afterwards.
